// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: widths, BRAM read latency and read-owner encoding shared by the data-port arbiter
// Contents: ADDR_W/DATA_W word-address and data widths, RD_LATENCY BRAM read latency,
//           owner_e (0 = core, 1 = loader) and rd_tag_t (one owner-pipeline stage).
package dmem_port_arbiter_pkg;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 32;
    localparam int RD_LATENCY = 2;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_LDR  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_rd_owner_pipe.sv
// rd_owner_pipe: remembers who issued each granted BRAM read until its data comes back
// Ports: clk, rstn (sync, active-low) | push, push_owner: read granted this cycle and its owner
//        out_valid, out_owner: read data on bram_dout this cycle and who it belongs to
module rd_owner_pipe
    import dmem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic push_owner,
    output logic out_valid,
    output logic out_owner
);

    rd_tag_t                  head;
    rd_tag_t [RD_LATENCY-1:0] stage;

    assign head = '{valid: push, owner: owner_e'(push_owner)};

    always_ff @(posedge clk) begin
        if (!rstn)
            stage <= '0;
        else
            stage <= {stage[RD_LATENCY-2:0], head};
    end

    assign out_valid = stage[RD_LATENCY-1].valid;
    assign out_owner = stage[RD_LATENCY-1].owner;

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one BRAM port between the core memory stage and the program loader
// Ports: clk, rstn (sync, active-low)
//        core_req/we/addr/wdata -> core_gnt, mem_stall, core_rvalid, core_rdata
//        ldr_req/we/addr/wdata  -> ldr_gnt, ldr_rvalid, ldr_rdata
//        bram_en/we/addr/din -> BRAM, bram_dout <- BRAM (2-cycle read latency)
// Core wins ties unless the loader has lost STARVE_LIMIT cycles in a row.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              mem_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       rd_push;
    logic       rd_push_owner;
    logic       rd_valid;
    logic       rd_owner;

    // Grants are gated by rstn so nothing reaches the BRAM while in reset.
    always_comb begin
        core_gnt      = rstn && core_req && !(ldr_req && starve_cnt == LIMIT);
        ldr_gnt       = rstn && ldr_req && !core_gnt;
        mem_stall     = core_req && !core_gnt;
        bram_en       = core_gnt || ldr_gnt;
        bram_we       = core_gnt ? core_we : ldr_gnt && ldr_we;
        bram_addr     = core_gnt ? core_addr : ldr_gnt ? ldr_addr : '0;
        bram_din      = core_gnt ? core_wdata : ldr_gnt ? ldr_wdata : '0;
        rd_push       = bram_en && !bram_we;
        rd_push_owner = ldr_gnt ? OWNER_LDR : OWNER_CORE;
    end

    always_ff @(posedge clk) begin
        if (!rstn || !ldr_req || ldr_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end

    rd_owner_pipe u_rd_owner_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .push       (rd_push),
        .push_owner (rd_push_owner),
        .out_valid  (rd_valid),
        .out_owner  (rd_owner)
    );

    // Read data is returned unqualified; rvalid alone marks it, and is dropped while in reset.
    assign core_rvalid = rstn && rd_valid && rd_owner == logic'(OWNER_CORE);
    assign ldr_rvalid  = rstn && rd_valid && rd_owner == logic'(OWNER_LDR);
    assign core_rdata  = bram_dout;
    assign ldr_rdata   = bram_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: table, directed and random checks of dmem_port_arbiter against a transaction-level model
module tb_dmem_port_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [16:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_gnt, mem_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [16:0] ldr_addr = '0;
    logic [31:0] ldr_wdata = '0;
    logic        ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        bram_en, bram_we;
    logic [16:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .mem_stall(mem_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // Unwritten words read as a fixed pattern of their address, standing in for preloaded contents.
    function automatic logic [31:0] init_val(input logic [16:0] a);
        return 32'hA000_0000 | {15'd0, a};
    endfunction

    // BRAM: write-first storage, registered address stage plus registered output = 2-cycle read.
    logic [31:0] ram [0:131071];
    bit          written [0:131071];
    logic [31:0] rd1;

    always @(posedge clk) begin
        if (bram_en && bram_we) begin
            ram[bram_addr]     <= bram_din;
            written[bram_addr] <= 1'b1;
        end
        if (bram_en && !bram_we)
            rd1 <= written[bram_addr] ? ram[bram_addr] : init_val(bram_addr);
        bram_dout <= rd1;
    end

    // Transaction-level model: memory contents, loader loss streak, responses keyed by due cycle.
    int          n_chk = 0, n_fail = 0, cyc = 0, losses = 0;
    logic [31:0] shadow [int];
    int          due_own [int];
    logic [31:0] due_dat [int];
    bit          eg_c, eg_l;

    function automatic logic [31:0] mread(input logic [16:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check combinational outputs, advance the model.
    task automatic tick(input logic rn, input logic cr, input logic cw, input logic [16:0] ca,
                        input logic [31:0] cd, input logic lr, input logic lw,
                        input logic [16:0] la, input logic [31:0] ld);
        logic        w;
        logic [16:0] a;
        logic [31:0] d;
        bit          ecv, elv;
        @(negedge clk);
        rstn = rn;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        #1;
        eg_l = rn && lr && (!cr || losses == LIMIT);
        eg_c = rn && cr && !eg_l;
        ecv  = rn && due_own.exists(cyc) && due_own[cyc] == 0;
        elv  = rn && due_own.exists(cyc) && due_own[cyc] == 1;
        w = eg_c ? cw : lw;
        a = eg_c ? ca : la;
        d = eg_c ? cd : ld;
        chk("core_gnt", core_gnt, eg_c);
        chk("ldr_gnt", ldr_gnt, eg_l);
        chk("mem_stall", mem_stall, cr && !eg_c);
        chk("bram_en", bram_en, eg_c || eg_l);
        if (eg_c || eg_l) begin
            chk("bram_we", bram_we, w);
            chk("bram_addr", bram_addr, a);
            if (w) chk("bram_din", bram_din, d);
        end else
            chk("bram_we_idle", bram_we, 0);
        chk("core_rvalid", core_rvalid, ecv);
        chk("ldr_rvalid", ldr_rvalid, elv);
        if (ecv) chk("core_rdata", core_rdata, due_dat[cyc]);
        if (elv) chk("ldr_rdata", ldr_rdata, due_dat[cyc]);
        if (due_own.exists(cyc)) begin
            due_own.delete(cyc);
            due_dat.delete(cyc);
        end
        if (!rn) begin
            losses = 0;
            due_own.delete();
            due_dat.delete();
        end else begin
            losses = (lr && !eg_l) ? (losses < LIMIT ? losses + 1 : losses) : 0;
            if (eg_c || eg_l) begin
                if (w) shadow[int'(a)] = d;
                else begin
                    due_own[cyc + 2] = eg_l ? 1 : 0;
                    due_dat[cyc + 2] = mread(a);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle();
        tick(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic core_rd(input logic [16:0] a);
        tick(1, 1, 0, a, '0, 0, 0, '0, '0);
    endtask

    task automatic ldr_rd(input logic [16:0] a);
        tick(1, 0, 0, '0, '0, 1, 0, a, '0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) tick(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Row bits: core_req core_we ldr_req ldr_we | exp core_gnt exp ldr_gnt exp mem_stall
    typedef struct packed {
        logic cr, cw, lr, lw, gc, gl, st;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [6:0] v);
        tbl.push_back(vec_t'(v));
    endtask

    bit          cp = 0, lp = 0;
    logic        cw_r = 0, lw_r = 0, rn_r;
    logic [16:0] ca_r = '0, la_r = '0;
    logic [31:0] cd_r = '0, ld_r = '0;

    initial begin
        do_reset(2);
        idle();
        chk("reset_core_rvalid", core_rvalid, 0);
        chk("reset_bram_en", bram_en, 0);

        add(7'b0000_000);
        add(7'b1000_100);
        add(7'b0011_010);
        for (int k = 0; k < 18; k++) add(k % 9 == 8 ? 7'b1011_011 : 7'b1011_100);
        add(7'b0010_010);
        for (int k = 0; k < 3; k++) add(7'b1110_100);
        add(7'b1000_100);
        for (int k = 0; k < 9; k++) add(k == 8 ? 7'b1110_011 : 7'b1110_100);
        foreach (tbl[i]) begin
            tick(1, tbl[i].cr, tbl[i].cw, 17'h20, 32'h1111_2222,
                 tbl[i].lr, tbl[i].lw, 17'h40, 32'h3333_4444);
            chk("tbl_core_gnt", core_gnt, tbl[i].gc);
            chk("tbl_ldr_gnt", ldr_gnt, tbl[i].gl);
            chk("tbl_mem_stall", mem_stall, tbl[i].st);
        end
        idle();
        idle();

        do_reset(1);
        core_rd(17'h10);
        chk("a_gnt", core_gnt, 1);
        chk("a_stall", mem_stall, 0);
        idle();
        chk("a_rvalid_early", core_rvalid, 0);
        idle();
        chk("a_rvalid", core_rvalid, 1);
        chk("a_rdata", core_rdata, 32'hA000_0010);
        chk("a_ldr_rvalid", ldr_rvalid, 0);
        idle();
        chk("a_rvalid_once", core_rvalid, 0);

        tick(1, 0, 0, '0, '0, 1, 1, 17'h100, 32'hDEAD_BEEF);
        chk("b_ldr_gnt", ldr_gnt, 1);
        core_rd(17'h100);
        chk("b_core_gnt", core_gnt, 1);
        idle();
        idle();
        chk("b_rvalid", core_rvalid, 1);
        chk("b_rdata", core_rdata, 32'hDEAD_BEEF);

        for (int i = 0; i < 6; i++) begin
            if (i < 4 && i % 2 == 0) core_rd(17'h200 + 17'(i));
            else if (i < 4) ldr_rd(17'h200 + 17'(i));
            else idle();
            chk("c_core_rvalid", core_rvalid, i >= 2 && i % 2 == 0);
            chk("c_ldr_rvalid", ldr_rvalid, i >= 2 && i % 2 == 1);
            chk("c_not_both", core_rvalid && ldr_rvalid, 0);
            if (i >= 2) chk("c_rdata", i % 2 ? ldr_rdata : core_rdata, 32'hA000_01FE + 32'(i));
        end

        core_rd(17'h10);
        chk("d_gnt", core_gnt, 1);
        tick(0, 1, 0, 17'h11, '0, 1, 0, 17'h12, '0);
        chk("d_rst_core_gnt", core_gnt, 0);
        chk("d_rst_ldr_gnt", ldr_gnt, 0);
        chk("d_rst_bram_en", bram_en, 0);
        idle();
        chk("d_dropped_rvalid", core_rvalid, 0);
        chk("d_starve_cnt", dut.starve_cnt, 0);
        core_rd(17'h30);
        chk("d_gnt_after", core_gnt, 1);
        idle();
        idle();
        chk("d_rvalid_after", core_rvalid, 1);
        chk("d_rdata_after", core_rdata, 32'hA000_0030);

        for (int i = 0; i < 3000; i++) begin
            if (!cp && $urandom_range(99) < 70) begin
                cp = 1;
                cw_r = 1'($urandom_range(1));
                ca_r = 17'($urandom_range(63));
                cd_r = $urandom;
            end
            if (!lp && $urandom_range(99) < 60) begin
                lp = 1;
                lw_r = 1'($urandom_range(1));
                la_r = 17'($urandom_range(63));
                ld_r = $urandom;
            end
            rn_r = $urandom_range(199) != 0;
            tick(rn_r, cp, cw_r, ca_r, cd_r, lp, lw_r, la_r, ld_r);
            if (eg_c) cp = 0;
            if (eg_l) lp = 0;
        end
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
